// File: rtl/cpu_bank_writer_pkg.sv
// Shared mapper definitions: CPU bus decode constants, bank register type and
// per-mapper default register decode for discrete-logic latch mappers.
package mapper_pkg;

  localparam int unsigned CPU_ADDR_BITS = 15;
  localparam int unsigned DATA_BITS     = 8;
  localparam logic [15:0] ROM_BASE      = 16'h8000;
  localparam logic [15:0] ROM_LAST      = 16'hFFFF;

  typedef logic [DATA_BITS-1:0]     bank_t;
  typedef logic [CPU_ADDR_BITS-1:0] cpu_addr_t;

  typedef enum logic [7:0] {
    MAPPER_CNROM        = 8'd3,
    MAPPER_COLOR_DREAMS = 8'd11,
    MAPPER_BNROM        = 8'd34,
    MAPPER_GXROM        = 8'd66,
    MAPPER_IREM_TAM_S1  = 8'd97
  } mapper_e;

  // Most latch mappers respond anywhere in $8000-$FFFF; TAM-S1 only decodes $8000-$BFFF.
  function automatic cpu_addr_t default_addr_mask(input mapper_e m);
    cpu_addr_t mask;
    mask = '0;
    if (m == MAPPER_IREM_TAM_S1) mask = 15'h4000;
    return mask;
  endfunction

  function automatic cpu_addr_t default_addr_match(input mapper_e m);
    cpu_addr_t match;
    match = '0;
    if (m == MAPPER_IREM_TAM_S1) match = 15'h0000;
    return match;
  endfunction

endpackage

// File: rtl/cpu_bank_writer_if.sv
// CPU-side bus and bank-register outputs of the write-capture stage.
interface cpu_bank_writer_if #(
  parameter int unsigned PRG_BITS = 2,
  parameter int unsigned CHR_BITS = 4
);
  import mapper_pkg::*;

  logic                romsel;
  logic                cpu_rw_in;
  cpu_addr_t           cpu_addr_in;
  bank_t               cpu_data_in;
  bank_t               flash_data_in;
  bank_t               bank;
  logic [PRG_BITS-1:0] prg_bank;
  logic [CHR_BITS-1:0] chr_bank;
  logic                bank_wr;
  logic                write_dropped;

  modport master (
    output romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, flash_data_in,
    input  bank, prg_bank, chr_bank, bank_wr, write_dropped
  );

  modport slave (
    input  romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, flash_data_in,
    output bank, prg_bank, chr_bank, bank_wr, write_dropped
  );
endinterface

// File: rtl/cpu_bank_writer_bus_conflict_and.sv
// Value actually seen by the latch: with bus conflicts the open-drain-like
// fight between CPU and flash resolves to the AND of both drivers.
module bus_conflict_and
  import mapper_pkg::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  bank_t i_cpu_data,
  input  bank_t i_flash_data,
  output bank_t o_value
);

  always_comb begin
    o_value = i_cpu_data;
    if (ENABLE) o_value = i_cpu_data & i_flash_data;
  end

endmodule

// File: rtl/cpu_bank_writer.sv
// Captures 6502 writes into ROM space on the falling edge of M2 and holds the
// bank register, with optional bus-conflict and RMW double-write suppression.
module cpu_bank_writer
  import mapper_pkg::*;
#(
  parameter cpu_addr_t   ADDR_MASK     = '0,
  parameter cpu_addr_t   ADDR_MATCH    = '0,
  parameter bit          BUS_CONFLICT  = 1'b1,
  parameter bit          IGNORE_CONSEC = 1'b1,
  parameter int unsigned PRG_BITS      = 2,
  parameter int unsigned CHR_BITS      = 4
) (
  input logic                m2,
  input logic                rst_n,
  cpu_bank_writer_if.slave   bus
);

  logic  w_rom_wr;
  logic  w_hit;
  logic  w_consec;
  bank_t w_value;

  bank_t r_bank;
  logic  r_bank_wr;
  logic  r_write_dropped;
  logic  r_prev_rom_wr;

  bus_conflict_and #(
    .ENABLE (BUS_CONFLICT)
  ) u_value (
    .i_cpu_data   (bus.cpu_data_in),
    .i_flash_data (bus.flash_data_in),
    .o_value      (w_value)
  );

  always_comb begin
    w_rom_wr = ~bus.romsel & ~bus.cpu_rw_in;
    w_hit    = w_rom_wr && ((bus.cpu_addr_in & ADDR_MASK) == ADDR_MATCH);
    w_consec = IGNORE_CONSEC && r_prev_rom_wr;
  end

  // prev_rom_wr follows every ROM write, decoded or not, so an RMW's
  // second write is dropped even when the first one missed the decode.
  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      r_bank          <= '0;
      r_bank_wr       <= 1'b0;
      r_write_dropped <= 1'b0;
      r_prev_rom_wr   <= 1'b0;
    end else begin
      r_prev_rom_wr   <= w_rom_wr;
      r_bank_wr       <= 1'b0;
      r_write_dropped <= 1'b0;
      if (w_hit) begin
        if (w_consec) begin
          r_write_dropped <= 1'b1;
        end else begin
          r_bank    <= w_value;
          r_bank_wr <= 1'b1;
        end
      end
    end
  end

  assign bus.bank          = r_bank;
  assign bus.prg_bank      = r_bank[PRG_BITS-1:0];
  assign bus.chr_bank      = r_bank[7:8-CHR_BITS];
  assign bus.bank_wr       = r_bank_wr;
  assign bus.write_dropped = r_write_dropped;

endmodule

// File: tb/tb_cpu_bank_writer.sv
// Directed bench for cpu_bank_writer: three instances (default, no bus conflict,
// A14 decode) share one CPU bus stimulus.
module tb_cpu_bank_writer;
  import mapper_pkg::*;

  logic      m2;
  logic      rst_n;
  logic      romsel;
  logic      rw;
  cpu_addr_t addr;
  bank_t     data;
  bank_t     flash;

  int unsigned n_cmp;
  int unsigned n_fail;

  cpu_bank_writer_if #(.PRG_BITS(2), .CHR_BITS(4)) bus_a ();
  cpu_bank_writer_if #(.PRG_BITS(2), .CHR_BITS(4)) bus_b ();
  cpu_bank_writer_if #(.PRG_BITS(2), .CHR_BITS(4)) bus_c ();

  assign bus_a.romsel = romsel;  assign bus_a.cpu_rw_in = rw;  assign bus_a.cpu_addr_in = addr;
  assign bus_a.cpu_data_in = data;  assign bus_a.flash_data_in = flash;
  assign bus_b.romsel = romsel;  assign bus_b.cpu_rw_in = rw;  assign bus_b.cpu_addr_in = addr;
  assign bus_b.cpu_data_in = data;  assign bus_b.flash_data_in = flash;
  assign bus_c.romsel = romsel;  assign bus_c.cpu_rw_in = rw;  assign bus_c.cpu_addr_in = addr;
  assign bus_c.cpu_data_in = data;  assign bus_c.flash_data_in = flash;

  cpu_bank_writer #(
    .ADDR_MASK(15'h0000), .ADDR_MATCH(15'h0000), .BUS_CONFLICT(1'b1),
    .IGNORE_CONSEC(1'b1), .PRG_BITS(2), .CHR_BITS(4)
  ) dut_a (.m2(m2), .rst_n(rst_n), .bus(bus_a));

  cpu_bank_writer #(
    .ADDR_MASK(15'h0000), .ADDR_MATCH(15'h0000), .BUS_CONFLICT(1'b0),
    .IGNORE_CONSEC(1'b1), .PRG_BITS(2), .CHR_BITS(4)
  ) dut_b (.m2(m2), .rst_n(rst_n), .bus(bus_b));

  cpu_bank_writer #(
    .ADDR_MASK(15'h4000), .ADDR_MATCH(15'h4000), .BUS_CONFLICT(1'b1),
    .IGNORE_CONSEC(1'b1), .PRG_BITS(2), .CHR_BITS(4)
  ) dut_c (.m2(m2), .rst_n(rst_n), .bus(bus_c));

  initial begin
    m2 = 1'b0;
    forever #5 m2 = ~m2;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One M2 cycle: drive on the rising edge, return just after the falling edge.
  task automatic cycle(input logic rs, input logic w_n, input cpu_addr_t a,
                       input bank_t d, input bank_t f);
    @(posedge m2);
    romsel = rs; rw = w_n; addr = a; data = d; flash = f;
    @(negedge m2);
    #1;
  endtask

  task automatic idle();
    cycle(1'b1, 1'b1, 15'h0000, 8'h00, 8'hFF);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    romsel = 1'b1; rw = 1'b1; addr = '0; data = '0; flash = 8'hFF;

    #2;
    check("rst_bank_a", bus_a.bank, 8'h00);
    check("rst_bank_wr_a", {7'd0, bus_a.bank_wr}, 8'h00);
    check("rst_dropped_a", {7'd0, bus_a.write_dropped}, 8'h00);
    check("rst_bank_c", bus_c.bank, 8'h00);

    @(posedge m2);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 15'h1234, 8'hA5, 8'h5A);
      check("idle_read_bank", bus_a.bank, 8'h00);
    end
    check("idle_read_bank_wr", {7'd0, bus_a.bank_wr}, 8'h00);

    cycle(1'b0, 1'b0, 15'h0000, 8'hF3, 8'h5F);
    check("bc_bank_a", bus_a.bank, 8'h53);
    check("bc_prg_a", {6'd0, bus_a.prg_bank}, 8'h03);
    check("bc_chr_a", {4'd0, bus_a.chr_bank}, 8'h05);
    check("bc_bank_wr_a", {7'd0, bus_a.bank_wr}, 8'h01);
    check("nobc_bank_b", bus_b.bank, 8'hF3);
    check("nobc_bank_wr_b", {7'd0, bus_b.bank_wr}, 8'h01);
    check("miss_a14_bank_c", bus_c.bank, 8'h00);
    check("miss_a14_wr_c", {7'd0, bus_c.bank_wr}, 8'h00);

    idle();
    check("bc_pulse_end_a", {7'd0, bus_a.bank_wr}, 8'h00);
    check("bc_hold_a", bus_a.bank, 8'h53);

    cycle(1'b0, 1'b0, 15'h0000, 8'h12, 8'hFF);
    check("rmw1_bank", bus_a.bank, 8'h12);
    check("rmw1_wr", {7'd0, bus_a.bank_wr}, 8'h01);
    check("rmw1_drop", {7'd0, bus_a.write_dropped}, 8'h00);
    cycle(1'b0, 1'b0, 15'h0000, 8'h34, 8'hFF);
    check("rmw2_bank", bus_a.bank, 8'h12);
    check("rmw2_wr", {7'd0, bus_a.bank_wr}, 8'h00);
    check("rmw2_drop", {7'd0, bus_a.write_dropped}, 8'h01);
    cycle(1'b0, 1'b0, 15'h0000, 8'h56, 8'hFF);
    check("rmw3_bank", bus_a.bank, 8'h12);
    check("rmw3_drop", {7'd0, bus_a.write_dropped}, 8'h01);
    cycle(1'b0, 1'b1, 15'h0000, 8'h00, 8'hFF);
    check("rmw_read_drop", {7'd0, bus_a.write_dropped}, 8'h00);
    check("rmw_read_bank", bus_a.bank, 8'h12);
    cycle(1'b0, 1'b0, 15'h0000, 8'h34, 8'hFF);
    check("rmw_retry_bank", bus_a.bank, 8'h34);
    check("rmw_retry_wr", {7'd0, bus_a.bank_wr}, 8'h01);

    idle();
    cycle(1'b0, 1'b0, 15'h0000, 8'hAA, 8'hFF);
    check("dec_miss_bank_c", bus_c.bank, 8'h00);
    check("dec_miss_wr_c", {7'd0, bus_c.bank_wr}, 8'h00);
    check("dec_miss_drop_c", {7'd0, bus_c.write_dropped}, 8'h00);
    cycle(1'b0, 1'b0, 15'h4000, 8'h55, 8'hFF);
    check("dec_consec_bank_c", bus_c.bank, 8'h00);
    check("dec_consec_drop_c", {7'd0, bus_c.write_dropped}, 8'h01);
    idle();
    cycle(1'b0, 1'b0, 15'h4000, 8'h55, 8'hFF);
    check("dec_hit_bank_c", bus_c.bank, 8'h55);
    check("dec_hit_wr_c", {7'd0, bus_c.bank_wr}, 8'h01);

    // Write stays on the bus across the reset pulse; reset must forget it.
    idle();
    cycle(1'b0, 1'b0, 15'h0000, 8'h77, 8'hFF);
    check("pre_reset_bank", bus_a.bank, 8'h77);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_bank", bus_a.bank, 8'h00);
    check("async_rst_wr", {7'd0, bus_a.bank_wr}, 8'h00);
    check("async_rst_chr", {4'd0, bus_a.chr_bank}, 8'h00);
    #1 rst_n = 1'b1;
    cycle(1'b0, 1'b0, 15'h0000, 8'h9C, 8'hFF);
    check("post_rst_bank", bus_a.bank, 8'h9C);
    check("post_rst_wr", {7'd0, bus_a.bank_wr}, 8'h01);
    check("post_rst_drop", {7'd0, bus_a.write_dropped}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
